// File: rtl/sub_seq_ctrl.sv
// Sequencing controller for the shared subtractor: one-pass SUB, and DIV/MOD by
// repeated subtraction of the latched divisor from a running remainder.
module sub_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sub_a_o,
  output logic [WIDTH-1:0] sub_b_o,
  input  logic [WIDTH-1:0] sub_out_i,
  input  logic             sub_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] OpSub = 2'b00;
  localparam logic [1:0] OpDiv = 2'b01;
  localparam logic [1:0] OpMod = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    q_d      = q_q;
    result_d = result_q;
    rem_d    = rem_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = a_i;
          q_d     = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        case (op_q)
          OpSub: begin
            result_d = sub_err_i ? '0 : sub_out_i;
            rem_d    = '0;
            err_d    = sub_err_i;
            state_d  = StDone;
          end
          OpDiv, OpMod: begin
            if (b_q == '0) begin
              err_d    = 1'b1;
              result_d = '0;
              rem_d    = a_q;
              state_d  = StDone;
            end else if (sub_err_i) begin
              // Borrow means acc < divisor: acc is the remainder, q the quotient.
              result_d = (op_q == OpDiv) ? q_q : acc_q;
              rem_d    = acc_q;
              err_d    = 1'b0;
              state_d  = StDone;
            end else begin
              acc_d = sub_out_i;
              q_d   = q_q + 1'b1;
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            rem_d    = '0;
            state_d  = StDone;
          end
        endcase
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign sub_a_o  = acc_q;
  assign sub_b_o  = b_q;
  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign rem_o    = rem_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl: a behavioural subtractor, an arithmetic
// reference model checked every cycle, and directed plus random operations.
module tb_sub_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic [7:0] sub_out;
  logic       sub_err;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] rem;
  logic       err;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  sub_seq_ctrl #(.WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .sub_a_o   (sub_a),
    .sub_b_o   (sub_b),
    .sub_out_i (sub_out),
    .sub_err_i (sub_err),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .rem_o     (rem),
    .err_o     (err)
  );

  // Combinational subtractor standing in for a_sub_b.
  assign sub_out = sub_a - sub_b;
  assign sub_err = (sub_a < sub_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] rem;
    logic       err;
    logic [9:0] runs;
  } exp_t;

  // Arithmetic definition of each operation and its RUN-cycle count.
  function automatic exp_t golden(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e = '0;
    e.runs = 10'd1;
    case (o)
      2'd0: begin
        e.err = (x < y);
        e.res = (x < y) ? 8'd0 : x - y;
      end
      2'd1, 2'd2: begin
        if (y == 8'd0) begin
          e.err = 1'b1;
          e.rem = x;
        end else begin
          e.rem  = x % y;
          e.res  = (o == 2'd1) ? x / y : x % y;
          e.runs = 10'(x / y) + 10'd1;
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  exp_t       g_now;
  exp_t       m_pend;
  logic [9:0] m_cnt;
  logic       m_busy, m_done, m_err;
  logic [7:0] m_res, m_rem;

  assign g_now = golden(op, a, b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
      m_pend <= '0;
      m_res  <= '0;
      m_rem  <= '0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_pend <= g_now;
        m_cnt  <= g_now.runs;
        m_busy <= 1'b1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 10'd1;
      if (m_cnt == 10'd1) begin
        m_done <= 1'b1;
        m_res  <= m_pend.res;
        m_rem  <= m_pend.rem;
        m_err  <= m_pend.err;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_result", 32'(result), 32'(m_res));
      check("cyc_rem", 32'(rem), 32'(m_rem));
      check("cyc_err", 32'(err), 32'(m_err));
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_rem"}, 32'(rem), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_sub_a"}, 32'(sub_a), 32'd0);
    check({tag, "_sub_b"}, 32'(sub_b), 32'd0);
  endtask

  // Issue one operation from IDLE, optionally poke start while busy, and check
  // the completion against the given expectations and accept-to-done latency.
  task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] e_res, input logic [7:0] e_rem,
                        input logic e_err, input int e_lat, input bit poke);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    op    = 2'($urandom);
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (poke && n == 1) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
    end else begin
      check({name, "_latency"}, 32'(n), 32'(e_lat));
      check({name, "_result"}, 32'(result), 32'(e_res));
      check({name, "_rem"}, 32'(rem), 32'(e_rem));
      check({name, "_err"}, 32'(err), 32'(e_err));
    end
    @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    int   dones;
    exp_t g;
    logic [1:0] ro;
    logic [7:0] ra, rb;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = 8'd0;
    b     = 8'd0;
    #2 rst = 1'b1;
    #1 check_zero("reset");
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("sub_5_1", 2'd0, 8'd5, 8'd1, 8'd4, 8'd0, 1'b0, 2, 1'b0);
    run_op("sub_1_5", 2'd0, 8'd1, 8'd5, 8'd0, 8'd0, 1'b1, 2, 1'b0);
    run_op("div_100_7", 2'd1, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16, 1'b0);
    run_op("mod_100_7", 2'd2, 8'd100, 8'd7, 8'd2, 8'd2, 1'b0, 16, 1'b0);
    run_op("div_255_1", 2'd1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 257, 1'b0);
    run_op("div_3_8", 2'd1, 8'd3, 8'd8, 8'd0, 8'd3, 1'b0, 2, 1'b0);
    run_op("div_9_0", 2'd1, 8'd9, 8'd0, 8'd0, 8'd9, 1'b1, 2, 1'b0);
    run_op("op11", 2'd3, 8'd7, 8'd2, 8'd0, 8'd0, 1'b1, 2, 1'b0);
    run_op("busy_poke", 2'd1, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16, 1'b1);

    // start held high: one SUB accepted every third edge.
    @(negedge clk);
    start = 1'b1;
    op    = 2'd0;
    a     = 8'd20;
    b     = 8'd3;
    dones = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("held_start_dones", 32'(dones), 32'd3);
    check("held_start_result", 32'(result), 32'd17);
    repeat (2) @(negedge clk);

    // Abort a long DIV with an asynchronous mid-cycle reset.
    @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    a     = 8'd200;
    b     = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("sub_8_8", 2'd0, 8'd8, 8'd8, 8'd0, 8'd0, 1'b0, 2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 8'd0;
        1:       rb = 8'($urandom_range(1, 4));
        default: rb = 8'($urandom);
      endcase
      g = golden(ro, ra, rb);
      run_op("rand", ro, ra, rb, g.res, g.rem, g.err, int'(g.runs) + 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_seq_ctrl.md
# sub_seq_ctrl

Sequencing controller for the calculator's shared 8-bit subtractor (`a_sub_b`). It accepts one operation at a time over a start/busy/done handshake and drives the subtractor's operand inputs. It performs plain subtraction in one pass, and division and modulo by repeated subtraction. It sits between the calculator's input/decode logic and the single subtractor instance, so no second arithmetic unit is needed for DIV/MOD.

## Interface
- `WIDTH`, 8: operand, result and remainder width; must match the subtractor width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only while `busy`=0.
- `op` in 2: 00 SUB, 01 DIV, 10 MOD, 11 reserved.
- `a` in WIDTH: operand A (minuend/dividend), captured on the accepting edge.
- `b` in WIDTH: operand B (subtrahend/divisor), captured on the accepting edge.
- `sub_a` out WIDTH: to subtractor `a`.
- `sub_b` out WIDTH: to subtractor `b`.
- `sub_out` in WIDTH: from subtractor `out` (A−B, valid when `sub_err`=0).
- `sub_err` in 1: from subtractor `sub_err`; 1 means A<B (borrow) and `sub_out` is don't-care.
- `busy` out 1: operation in progress, including the DONE cycle.
- `done` out 1: one-cycle pulse marking `result`/`rem`/`err` valid.
- `result` out WIDTH: difference (SUB), quotient (DIV) or remainder (MOD).
- `rem` out WIDTH: remainder (DIV/MOD); 0 for SUB.
- `err` out 1: SUB underflow, divide by zero, or reserved op.

## Operation
- States: IDLE, RUN, DONE. Registers: `op_r`, `a_r`, `b_r`, `acc` (running remainder), `q` (quotient counter).
- IDLE:
  - `start`=1 latches `op`, `a`, `b`; sets `acc`←`a`, `q`←0; enters RUN.
  - `start` is ignored in any other state; `a`, `b`, `op` are don't-care outside the accepting edge.
- Operand drive: `sub_a`=`acc`, `sub_b`=`b_r` in every state. The subtractor is combinational; its outputs are sampled on RUN edges only.
- RUN, SUB: on the first RUN edge:
  - `result`←`sub_err` ? 0 : `sub_out`; `rem`←0; `err`←`sub_err`.
  - Go to DONE.
- RUN, DIV/MOD, evaluated on each RUN edge in priority order:
  - `b_r`==0: `err`←1, `result`←0, `rem`←`a_r`; go to DONE.
  - `sub_err`=1: finish. DIV: `result`←`q`, `rem`←`acc`. MOD: `result`←`acc`, `rem`←`acc`. `err`←0; go to DONE.
  - Otherwise: `acc`←`sub_out`, `q`←`q`+1; stay in RUN.
- RUN, op 11: `err`←1, `result`←0, `rem`←0; go to DONE on the first RUN edge.
- DONE: `done`=1 for exactly one cycle; go to IDLE on the next edge.
- `result`, `rem`, `err` hold their values until the next completion. They are not cleared on a new start.
- Width rules:
  - `q` is WIDTH bits and cannot overflow, since the maximum quotient is 2^WIDTH−1 (a=255, b=1).
  - `acc` never exceeds `a_r`.
  - No sign handling; all operands are unsigned.
- Reset, asserted at any time including mid-RUN:
  - State←IDLE; all registers and outputs←0 (`busy`, `done`, `result`, `rem`, `err`, `sub_a`, `sub_b`).
  - An operation interrupted by reset produces no `done`.
- `start` held high continuously starts a new operation on the first IDLE edge after each DONE.

## Timing
- Accepting edge E0 (IDLE, `start`=1). `busy`=1 from after E0 until after the DONE edge.
- SUB and op 11: one RUN cycle. `done` is high in the cycle after E1; back in IDLE after E2. Total is 2 cycles from accept to IDLE.
- DIV/MOD: Q+1 RUN cycles, where Q is the quotient (1 RUN cycle for b=0), then one DONE cycle. Worst case is a=255, b=1: 256 RUN cycles + 1 DONE.
- Minimum start-to-start spacing is 3 cycles (E0, E1, DONE edge, then accept on the next IDLE edge).
- `done` and `busy` are registered; there is no combinational path from `start` to any output.

## Test plan
- Reset: assert `rst` asynchronously mid-clock → `busy`=`done`=`err`=0, `result`=`rem`=0 immediately; no `done` after release.
- SUB: a=5, b=1 → `result`=4, `err`=0, `done` pulses once, 2 cycles after accept. Then a=1, b=5 → `err`=1, `result`=0.
- DIV: a=100, b=7 → `result`=14, `rem`=2, `done` 16 cycles after accept (15 RUN + DONE). MOD with the same operands → `result`=2.
- Boundaries:
  - a=255, b=1 DIV → `result`=255, `rem`=0 after 256 RUN cycles.
  - a=3, b=8 DIV → `result`=0, `rem`=3 after 1 RUN cycle.
  - a=9, b=0 DIV → `err`=1, `rem`=9.
- Handshake: pulse `start` with new operands while `busy`=1 → ignored; results match the first operation. Holding `start` high → back-to-back operations with one `done` each. Op 11 → `err`=1.
- Abort: assert `rst` in the middle of a=200, b=1 DIV → IDLE with zeroed outputs. A following SUB a=8, b=8 → `result`=0, `err`=0.
